// File: rtl/lpc_periph_pkg.sv
// LPC TPM-locality peripheral: shared nibble codes, FSM state encodings and SYNC helper.
package lpc_periph_pkg;

  localparam logic [3:0] START_TPM     = 4'b0101;
  localparam logic [3:0] CYCTYPE_IO_RD = 4'b0000;
  localparam logic [3:0] CYCTYPE_IO_WR = 4'b0010;
  localparam logic [3:0] SYNC_READY    = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT    = 4'b0110;
  localparam logic [3:0] SYNC_ERR      = 4'b1010;
  localparam logic [3:0] TAR_IDLE      = 4'b1111;

  // The cycle type is decoded on the clock that leaves StStart, so StCycType is never resident.
  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StStart   = 4'd1;
  localparam logic [3:0] StCycType = 4'd2;
  localparam logic [3:0] StAddr    = 4'd3;
  localparam logic [3:0] StWdata   = 4'd4;
  localparam logic [3:0] StHtar    = 4'd5;
  localparam logic [3:0] StSync    = 4'd6;
  localparam logic [3:0] StRdata   = 4'd7;
  localparam logic [3:0] StPtar    = 4'd8;

  function automatic logic [3:0] sync_code(input logic ready, input logic err);
    if (ready)    return SYNC_READY;
    else if (err) return SYNC_ERR;
    else          return SYNC_LWAIT;
  endfunction

endpackage

// File: rtl/lpc_periph_if.sv
// Byte-wide data-provider handshake between the LPC front-end (master) and register block.
interface lpc_periph_if;
  logic [15:0] addr;
  logic        data_wr;
  logic        wr_done;
  logic        data_req;
  logic        data_rd;

  modport master (output addr, output data_wr, output data_req, input wr_done, input data_rd);
  modport slave  (input addr, input data_wr, input data_req, output wr_done, output data_rd);
endinterface

// File: rtl/lpc_periph.sv
// LPC peripheral front-end for TPM locality cycles: decodes host framing, drives SYNC/TAR/read
// data on LAD and initiates the byte handshake towards the register block.
module lpc_periph
  import lpc_periph_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 255,
  parameter logic [3:0]  TPM_START    = START_TPM
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         lframe_n_i,
  inout  wire  [3:0]   lad_io,
  inout  wire  [7:0]   data_io,
  lpc_periph_if.master dp_io
);

  localparam logic [9:0] TimeoutLast = 10'(SYNC_TIMEOUT - 1);

  logic [3:0]  state_q, state_d;
  logic [3:0]  start_q, start_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  nib_q, nib_d;
  logic [9:0]  to_q, to_d;
  logic        data_wr_q, data_wr_d;
  logic        data_req_q, data_req_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;

  logic        hs_active, hs_closed;
  logic        lad_oe, data_oe;
  logic [3:0]  lad_out;

  assign hs_active = data_wr_q | data_req_q;
  // An abandoned handshake blocks new ones until the responder has dropped both strobes.
  assign hs_closed = !dp_io.wr_done && !dp_io.data_rd && !pend_q;

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    nib_d      = nib_q;
    to_d       = to_q;
    data_wr_d  = data_wr_q;
    data_req_d = data_req_q;
    ready_d    = ready_q;
    err_d      = err_q;
    pend_d     = pend_q;

    if (pend_q && !dp_io.wr_done && !dp_io.data_rd) pend_d = 1'b0;

    if (!lframe_n_i) begin
      state_d    = StStart;
      start_d    = lad_io;
      data_wr_d  = 1'b0;
      data_req_d = 1'b0;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      if (hs_active) pend_d = 1'b1;
    end else begin
      case (state_q)
        StStart: begin
          nib_d = 2'd0;
          if (start_q == TPM_START && (lad_io == CYCTYPE_IO_RD || lad_io == CYCTYPE_IO_WR)) begin
            state_d = StAddr;
            is_wr_d = (lad_io == CYCTYPE_IO_WR);
          end else begin
            state_d = StIdle;
          end
        end
        StAddr: begin
          addr_d = {addr_q[11:0], lad_io};
          nib_d  = nib_q + 2'd1;
          if (nib_q == 2'd3) state_d = is_wr_q ? StWdata : StHtar;
        end
        StWdata: begin
          if (!nib_q[0]) begin
            data_d[3:0] = lad_io;
            nib_d       = 2'd1;
          end else begin
            data_d[7:4] = lad_io;
            nib_d       = 2'd0;
            state_d     = StHtar;
          end
        end
        StHtar: begin
          if (nib_q == 2'd0) begin
            nib_d = 2'd1;
          end else begin
            nib_d   = 2'd0;
            state_d = StSync;
            to_d    = 10'd0;
            ready_d = 1'b0;
            err_d   = 1'b0;
            if (hs_closed) begin
              data_wr_d  = is_wr_q;
              data_req_d = !is_wr_q;
            end
          end
        end
        StSync: begin
          if (ready_q || err_q) begin
            ready_d = 1'b0;
            err_d   = 1'b0;
            state_d = is_wr_q ? StPtar : StRdata;
          end else if (data_wr_q && dp_io.wr_done) begin
            data_wr_d = 1'b0;
            ready_d   = 1'b1;
          end else if (data_req_q && dp_io.data_rd) begin
            data_req_d = 1'b0;
            data_d     = data_io;
            ready_d    = 1'b1;
          end else if (to_q == TimeoutLast) begin
            err_d      = 1'b1;
            data_wr_d  = 1'b0;
            data_req_d = 1'b0;
            pend_d     = hs_active;
            if (!is_wr_q) data_d = 8'hFF;
          end else begin
            to_d = to_q + 10'd1;
            if (!hs_active && hs_closed) begin
              data_wr_d  = is_wr_q;
              data_req_d = !is_wr_q;
            end
          end
        end
        StRdata: begin
          if (nib_q == 2'd0) begin
            nib_d = 2'd1;
          end else begin
            nib_d   = 2'd0;
            state_d = StPtar;
          end
        end
        StPtar: begin
          if (nib_q == 2'd0) begin
            nib_d = 2'd1;
          end else begin
            nib_d   = 2'd0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      start_q    <= 4'h0;
      is_wr_q    <= 1'b0;
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      nib_q      <= 2'd0;
      to_q       <= 10'd0;
      data_wr_q  <= 1'b0;
      data_req_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      nib_q      <= nib_d;
      to_q       <= to_d;
      data_wr_q  <= data_wr_d;
      data_req_q <= data_req_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    lad_oe  = 1'b0;
    lad_out = TAR_IDLE;
    case (state_q)
      StSync: begin
        lad_oe  = 1'b1;
        lad_out = sync_code(ready_q, err_q);
      end
      StRdata: begin
        lad_oe  = 1'b1;
        lad_out = nib_q[0] ? data_q[7:4] : data_q[3:0];
      end
      StPtar: begin
        lad_oe  = (nib_q == 2'd0);
        lad_out = TAR_IDLE;
      end
      default: ;
    endcase
  end

  // Never fight the responder on data_io, even if it misbehaves mid-write.
  assign data_oe = data_wr_q && !dp_io.data_rd;

  assign lad_io  = lad_oe  ? lad_out : 4'bz;
  assign data_io = data_oe ? data_q  : 8'bz;

  assign dp_io.addr     = addr_q;
  assign dp_io.data_wr  = data_wr_q;
  assign dp_io.data_req = data_req_q;

endmodule

// File: tb/tb_lpc_periph.sv
// Directed bench for lpc_periph: vector table for full cycles plus timeout, abort and reset cases.
module tb_lpc_periph;
  import lpc_periph_pkg::*;

  localparam int RespSilent = 0;
  localparam int RespAuto   = 1;
  localparam int RespStuck  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lframe_n = 1'b1;
  logic       host_oe = 1'b0;
  logic [3:0] host_lad = 4'h0;
  logic       wr_done = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] resp_byte = 8'h00;
  int         resp_mode = RespAuto;
  logic       wr_s, rq_s;

  wire [3:0] lad;
  wire [7:0] dio;

  lpc_periph_if dp ();

  assign lad        = host_oe ? host_lad : 4'bz;
  assign dio        = data_rd ? resp_byte : 8'bz;
  assign dp.wr_done = wr_done;
  assign dp.data_rd = data_rd;

  lpc_periph #(.SYNC_TIMEOUT(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .lframe_n_i(lframe_n),
    .lad_io    (lad),
    .data_io   (dio),
    .dp_io     (dp)
  );

  always #5 clk = ~clk;

  // Responder: reacts one clock after seeing data_wr / data_req.
  always begin
    @(negedge clk);
    wr_s = dp.data_wr;
    rq_s = dp.data_req;
    @(posedge clk);
    #1;
    case (resp_mode)
      RespAuto:  begin wr_done = wr_s; data_rd = rq_s; end
      RespStuck: begin wr_done = 1'b0; data_rd = 1'b1; end
      default:   begin wr_done = 1'b0; data_rd = 1'b0; end
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic lf, input logic [3:0] nib);
    step();
    lframe_n = lf;
    host_oe  = 1'b1;
    host_lad = nib;
  endtask

  // Leaves the bench in the second HTAR clock with LAD released by the host.
  task automatic send_hdr(input logic [3:0] st, input logic wr, input logic [15:0] a,
                          input logic [7:0] wd);
    drive(1'b0, st);
    drive(1'b1, wr ? CYCTYPE_IO_WR : CYCTYPE_IO_RD);
    for (int k = 0; k < 4; k++) drive(1'b1, a[15-4*k -: 4]);
    if (wr) begin
      drive(1'b1, wd[3:0]);
      drive(1'b1, wd[7:4]);
    end
    drive(1'b1, TAR_IDLE);
    step();
    host_oe = 1'b0;
  endtask

  task automatic chk_lad(input string name, input logic [3:0] exp);
    chk({name, " oe"}, 32'(dut.lad_oe), 32'd1);
    chk(name, 32'(lad), 32'(exp));
  endtask

  typedef struct packed {
    logic        lf;
    logic        hoe;
    logic [3:0]  hlad;
    logic        eoe;
    logic [3:0]  elad;
    logic        ewr;
    logic        ereq;
    logic        caddr;
    logic [15:0] eaddr;
    logic [7:0]  edio;
    logic [7:0]  resp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lf, input logic hoe, input logic [3:0] hlad, input logic eoe,
                     input logic [3:0] elad, input logic ewr, input logic ereq,
                     input logic caddr, input logic [15:0] eaddr, input logic [7:0] edio,
                     input logic [7:0] resp);
    vecs.push_back('{lf, hoe, hlad, eoe, elad, ewr, ereq, caddr, eaddr, edio, resp});
  endtask

  // TPM read with an auto responder answering one clock after data_req.
  task automatic add_read_rows(input logic [15:0] a, input logic [7:0] r);
    add(0, 1, START_TPM,     0, 0, 0, 0, 0, 0, 0, r);
    add(1, 1, CYCTYPE_IO_RD, 0, 0, 0, 0, 0, 0, 0, r);
    for (int k = 0; k < 4; k++) add(1, 1, a[15-4*k -: 4], 0, 0, 0, 0, 0, 0, 0, r);
    add(1, 1, TAR_IDLE,      0, 0,          0, 0, 1, a, 0, r);
    add(1, 0, 0,             0, 0,          0, 0, 0, 0, 0, r);
    add(1, 0, 0,             1, SYNC_LWAIT, 0, 1, 1, a, 0, r);
    add(1, 0, 0,             1, SYNC_LWAIT, 0, 1, 0, 0, 0, r);
    add(1, 0, 0,             1, SYNC_READY, 0, 0, 0, 0, 0, r);
    add(1, 0, 0,             1, r[3:0],     0, 0, 0, 0, 0, r);
    add(1, 0, 0,             1, r[7:4],     0, 0, 0, 0, 0, r);
    add(1, 0, 0,             1, TAR_IDLE,   0, 0, 0, 0, 0, r);
    add(1, 0, 0,             0, 0,          0, 0, 1, a, 0, r);
    add(1, 0, 0,             0, 0,          0, 0, 0, 0, 0, r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    vec_t v;

    // Write 0x0008 <- 0x0F
    add(0, 1, START_TPM,     0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, CYCTYPE_IO_WR, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h0,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h0,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h0,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h8,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'hF,          0, 0, 0, 0, 1, 16'h0008, 0, 0);
    add(1, 1, 4'h0,          0, 0, 0, 0, 1, 16'h0008, 0, 0);
    add(1, 1, TAR_IDLE,      0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,             1, SYNC_LWAIT, 1, 0, 1, 16'h0008, 8'h0F, 0);
    add(1, 0, 0,             1, SYNC_LWAIT, 1, 0, 1, 16'h0008, 8'h0F, 0);
    add(1, 0, 0,             1, SYNC_READY, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,             1, TAR_IDLE,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0,             0, 0,          0, 0, 0, 0, 0, 0);
    add(1, 0, 0,             0, 0,          0, 0, 0, 0, 0, 0);
    add_read_rows(16'h0F00, 8'hA5);
    add_read_rows(16'h2000, 8'h3C);
    // Non-TPM START: whole frame ignored, addr keeps 0x2000
    add(0, 1, 4'h0,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, CYCTYPE_IO_RD, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h2,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h0,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h0,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'h1,          0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, TAR_IDLE,      0, 0, 0, 0, 1, 16'h2000, 0, 0);
    add(1, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,             0, 0, 0, 0, 1, 16'h2000, 0, 0);
    add(1, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) step();
    chk("reset lad_oe", 32'(dut.lad_oe), 32'd0);
    chk("reset data_oe", 32'(dut.data_oe), 32'd0);
    chk("reset data_wr", 32'(dp.data_wr), 32'd0);
    chk("reset data_req", 32'(dp.data_req), 32'd0);
    chk("reset addr", 32'(dp.addr), 32'h0000);
    chk("reset state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step();
      lframe_n  = v.lf;
      host_oe   = v.hoe;
      host_lad  = v.hlad;
      resp_byte = v.resp;
      #1;
      chk($sformatf("vec%0d lad_oe", i), 32'(dut.lad_oe), 32'(v.eoe));
      if (v.eoe) chk($sformatf("vec%0d lad", i), 32'(lad), 32'(v.elad));
      chk($sformatf("vec%0d data_wr", i), 32'(dp.data_wr), 32'(v.ewr));
      chk($sformatf("vec%0d data_req", i), 32'(dp.data_req), 32'(v.ereq));
      chk($sformatf("vec%0d data_oe", i), 32'(dut.data_oe), 32'(v.ewr));
      if (v.ewr) chk($sformatf("vec%0d data_io", i), 32'(dio), 32'(v.edio));
      if (v.caddr) chk($sformatf("vec%0d addr", i), 32'(dp.addr), 32'(v.eaddr));
    end

    // Silent responder: 8 long-wait clocks, error SYNC, read data forced to FF
    resp_mode = RespSilent;
    send_hdr(START_TPM, 1'b0, 16'h0004, 8'h00);
    step();
    chk("timeout req", 32'(dp.data_req), 32'd1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (dut.lad_oe && lad == SYNC_LWAIT) n++;
      else break;
      step();
    end
    chk("timeout lwait count", 32'(n), 32'd8);
    chk_lad("timeout err sync", SYNC_ERR);
    chk("timeout req dropped", 32'(dp.data_req), 32'd0);
    step(); chk_lad("timeout rdata lo", 4'hF);
    step(); chk_lad("timeout rdata hi", 4'hF);
    step(); chk_lad("timeout ptar", TAR_IDLE);
    step(); chk("timeout ptar release", 32'(dut.lad_oe), 32'd0);

    // Stuck data_rd: next read holds off data_req until it clears
    resp_mode = RespStuck;
    resp_byte = 8'h3C;
    send_hdr(START_TPM, 1'b0, 16'h0010, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_lad($sformatf("stuck lwait%0d", k), SYNC_LWAIT);
      chk($sformatf("stuck req%0d", k), 32'(dp.data_req), 32'd0);
    end
    resp_mode = RespAuto;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dp.data_req) seen = 1'b1;
      if (dut.lad_oe && lad == SYNC_READY) break;
    end
    chk("stuck req issued", 32'(seen), 32'd1);
    chk_lad("stuck ready", SYNC_READY);
    step(); chk_lad("stuck rdata lo", 4'hC);
    step(); chk_lad("stuck rdata hi", 4'h3);
    step(); chk_lad("stuck ptar", TAR_IDLE);
    step();

    // LFRAME# abort in ADDR nibble 2, then a clean write
    drive(1'b0, START_TPM);
    drive(1'b1, CYCTYPE_IO_WR);
    drive(1'b1, 4'h0);
    drive(1'b1, 4'h0);
    drive(1'b0, 4'hF);
    chk("abort lad_oe", 32'(dut.lad_oe), 32'd0);
    drive(1'b1, 4'h0);
    chk("abort lad_oe2", 32'(dut.lad_oe), 32'd0);
    step();
    host_oe = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("abort idle%0d lad_oe", k), 32'(dut.lad_oe), 32'd0);
      chk($sformatf("abort idle%0d hs", k), 32'({dp.data_wr, dp.data_req}), 32'd0);
    end
    send_hdr(START_TPM, 1'b1, 16'h000C, 8'h5A);
    step();
    chk("post-abort data_wr", 32'(dp.data_wr), 32'd1);
    chk("post-abort data_io", 32'(dio), 32'h5A);
    chk("post-abort addr", 32'(dp.addr), 32'h000C);
    for (int k = 0; k < 12; k++) begin
      if (dut.lad_oe && lad == SYNC_READY) break;
      step();
    end
    chk_lad("post-abort ready", SYNC_READY);
    chk("post-abort wr dropped", 32'(dp.data_wr), 32'd0);
    step(); chk_lad("post-abort ptar", TAR_IDLE);
    step(); chk("post-abort release", 32'(dut.lad_oe), 32'd0);
    step();

    // Reset while a write handshake is open
    resp_mode = RespSilent;
    send_hdr(START_TPM, 1'b1, 16'h0020, 8'h77);
    step();
    chk("rst pre data_wr", 32'(dp.data_wr), 32'd1);
    chk("rst pre data_oe", 32'(dut.data_oe), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("rst data_wr", 32'(dp.data_wr), 32'd0);
    chk("rst lad_oe", 32'(dut.lad_oe), 32'd0);
    chk("rst data_oe", 32'(dut.data_oe), 32'd0);
    chk("rst state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
